// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, conversion FSM states and the double-dabble step shared by the scan driver.
package seg7_pkg;
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_MINUS = 8'h40;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  // Layout {hundreds, tens, units, binary}: add-3 on large BCD nibbles, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] a;
    a = v;
    for (int i = 0; i < 3; i++)
      if (a[8+4*i +: 4] >= 4'd5) a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
    return {a[18:0], 1'b0};
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit plus blank flag to active-high segment pattern (dp always off).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (!blank)
      case (digit)
        4'd0: seg = SEG_0;
        4'd1: seg = SEG_1;
        4'd2: seg = SEG_2;
        4'd3: seg = SEG_3;
        4'd4: seg = SEG_4;
        4'd5: seg = SEG_5;
        4'd6: seg = SEG_6;
        4'd7: seg = SEG_7;
        4'd8: seg = SEG_8;
        4'd9: seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: latches CPU output values, converts them to BCD by double-dabble and scans 4 digits.
// Define SIGNED_DISP_EN to show din as two's complement with a minus sign on digit 3.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       busy
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  state_t state, state_nxt;
  logic [19:0] dd;
  logic [2:0] iter;
  logic [7:0] pend_val, din_mag, start_val, dec_seg;
  logic pending, start, consume, din_neg, start_neg, conv_neg, pend_neg, disp_neg, blank;
  logic [3:0] disp_h, disp_t, disp_u, dig;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
`ifdef SIGNED_DISP_EN
  assign din_neg = din[7];
  assign din_mag = din[7] ? -din : din;
`else
  assign din_neg = 1'b0;
  assign din_mag = din;
`endif
  assign busy = state != IDLE;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    start = 1'b0;
    start_val = din_mag;
    start_neg = din_neg;
    case (state)
      IDLE: if (load || pending) begin
        start = 1'b1;
        start_val = load ? din_mag : pend_val;
        start_neg = load ? din_neg : pend_neg;
      end
      CONV: state_nxt = iter == 3'd7 ? DONE : CONV;
      DONE: begin
        start = pending;
        start_val = pend_val;
        start_neg = pend_neg;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = CONV;
  end
  // The pending slot is consumed whenever a conversion starts from it rather than from din.
  assign consume = start && (state != IDLE || !load);
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      pend_val <= '0;
      pend_neg <= 1'b0;
      dd <= '0;
      iter <= '0;
      conv_neg <= 1'b0;
      disp_h <= '0;
      disp_t <= '0;
      disp_u <= '0;
      disp_neg <= 1'b0;
    end else begin
      if (load && state != IDLE) begin
        pending <= 1'b1;
        pend_val <= din_mag;
        pend_neg <= din_neg;
      end else if (consume) pending <= 1'b0;
      if (start) begin
        dd <= {12'd0, start_val};
        iter <= '0;
        conv_neg <= start_neg;
      end else if (state == CONV) begin
        dd <= dd_step(dd);
        iter <= iter + 3'd1;
      end
      if (state == DONE) begin
        disp_h <= dd[19:16];
        disp_t <= dd[15:12];
        disp_u <= dd[11:8];
        disp_neg <= conv_neg;
      end
    end
  end
  assign dig = idx == 2'd0 ? disp_u : idx == 2'd1 ? disp_t : disp_h;
  assign blank = idx == 2'd1 ? (disp_h == 4'd0 && disp_t == 4'd0) : (idx == 2'd2 && disp_h == 4'd0);
  seg7_decode u_dec (
    .digit(dig),
    .blank(blank),
    .seg  (dec_seg)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      seg <= SEG_BLANK;
      an <= '0;
    end else begin
      cnt <= cnt == CW'(SCAN_DIV - 1) ? '0 : cnt + 1'b1;
      if (cnt == CW'(SCAN_DIV - 1)) idx <= idx + 2'd1;
      an <= 4'b0001 << idx;
      seg <= idx == 2'd3 ? (disp_neg ? SEG_MINUS : SEG_BLANK) : dec_seg;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized self-checking bench against a decimal-arithmetic display model.
module tb_seg7_scan_driver;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] seg;
  logic [3:0] an;
  logic busy;
  int errors = 0, checks = 0;
  logic [7:0] shown = '0;
  logic [7:0] tab [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  seg7_scan_driver #(.SCAN_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .load(load),
    .din (din),
    .seg (seg),
    .an  (an),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int mag(logic [7:0] d);
`ifdef SIGNED_DISP_EN
    return d[7] ? 256 - int'(d) : int'(d);
`else
    return int'(d);
`endif
  endfunction

  function automatic bit is_neg(logic [7:0] d);
`ifdef SIGNED_DISP_EN
    return d[7];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_seg(logic [7:0] d, int pos);
    int v, h, t, u;
    v = mag(d);
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    if (pos == 3) return is_neg(d) ? 8'h40 : 8'h00;
    if (pos == 2) return h == 0 ? 8'h00 : tab[h];
    if (pos == 1) return v < 10 ? 8'h00 : tab[t];
    return tab[u];
  endfunction

  function automatic int an_idx(logic [3:0] a);
    case (a)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    load = 1'b0;
    repeat (3) begin
      tick;
      checks++;
      if (seg !== 8'h00 || an !== 4'h0) begin
        errors++;
        $display("FAIL reset_hold: seg=%h an=%b expected seg=00 an=0000", seg, an);
      end
    end
    rst = 1'b0;
    shown = 8'd0;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 4; c++) begin
        tick;
        checks++;
        if (an !== 4'(1 << s) || seg !== exp_seg(8'd0, s)) begin
          errors++;
          $display("FAIL reset_scan: seg=%h an=%b expected seg=%h an=%b", seg, an, exp_seg(8'd0, s), 4'(1 << s));
        end
      end
  endtask

  task automatic test_convert;
    int n, idx;
    din = 8'd237;
    load = 1'b1;
    tick;
    load = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy) n++;
      tick;
    end
    shown = 8'd237;
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL busy_len: busy cycles=%0d expected 9", n);
    end
    repeat (16) begin
      tick;
      idx = an_idx(an);
      checks++;
      if (idx < 0 || seg !== exp_seg(8'd237, idx)) begin
        errors++;
        $display("FAIL convert_237: seg=%h an=%b expected seg=%h", seg, an, exp_seg(8'd237, idx));
      end
    end
  endtask

  task automatic test_back_to_back;
    int idx;
    logic [7:0] old, want;
    old = shown;
    din = 8'd5;
    load = 1'b1;
    tick;
    load = 1'b0;
    tick;
    din = 8'd99;
    load = 1'b1;
    tick;
    din = 8'd100;
    tick;
    load = 1'b0;
    for (int k = 4; k <= 32; k++) begin
      tick;
      idx = an_idx(an);
      if (k == 10 || k == 19) continue;
      want = k < 10 ? old : k < 19 ? 8'd5 : 8'd100;
      checks++;
      if (idx < 0 || seg !== exp_seg(want, idx)) begin
        errors++;
        $display("FAIL back_to_back k=%0d: seg=%h an=%b expected seg=%h (value %0d)", k, seg, an, exp_seg(want, idx), want);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_idle: busy=%b expected 0", busy);
    end
    shown = 8'd100;
  endtask

  task automatic test_rst_abort;
    int idx;
    din = 8'd8;
    load = 1'b1;
    tick;
    load = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0 || an !== 4'h0 || seg !== 8'h00) begin
      errors++;
      $display("FAIL rst_abort: busy=%b an=%b seg=%h expected 0/0000/00", busy, an, seg);
    end
    din = 8'd77;
    load = 1'b1;
    tick;
    load = 1'b0;
    rst = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL load_with_rst: busy=%b expected 0", busy);
    end
    shown = 8'd0;
    repeat (16) begin
      tick;
      idx = an_idx(an);
      checks++;
      if (idx < 0 || seg !== exp_seg(8'd0, idx)) begin
        errors++;
        $display("FAIL rst_display: seg=%h an=%b expected seg=%h", seg, an, exp_seg(8'd0, idx));
      end
    end
  endtask

  task automatic test_scan_wrap;
    int cnt[4];
    int idx, prev, run, order_bad, run_bad;
    cnt = '{0, 0, 0, 0};
    prev = -1;
    run = 0;
    order_bad = 0;
    run_bad = 0;
    for (int c = 0; c < 32; c++) begin
      tick;
      idx = an_idx(an);
      if (idx < 0) begin
        order_bad++;
        continue;
      end
      cnt[idx]++;
      if (prev >= 0 && idx != prev) begin
        if (idx != (prev + 1) % 4) order_bad++;
        if (run != 4 && run != c) run_bad++;
        run = 0;
      end
      run++;
      prev = idx;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt[i] != 8) begin
        errors++;
        $display("FAIL scan_count an[%0d]: cycles=%0d expected 8", i, cnt[i]);
      end
    end
    checks++;
    if (order_bad != 0 || run_bad != 0) begin
      errors++;
      $display("FAIL scan_order: bad steps=%0d bad runs=%0d expected 0/0", order_bad, run_bad);
    end
  endtask

  task automatic test_values(input logic [7:0] vals[$], input string name);
    int idx;
    foreach (vals[i]) begin
      din = vals[i];
      load = 1'b1;
      tick;
      load = 1'b0;
      for (int w = 0; w < 30 && busy; w++) tick;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_timeout: busy=%b expected 0 for din=%h", name, busy, vals[i]);
      end
      repeat (2) tick;
      repeat (16) begin
        tick;
        idx = an_idx(an);
        checks++;
        if (idx < 0 || seg !== exp_seg(vals[i], idx)) begin
          errors++;
          $display("FAIL %s din=%h: seg=%h an=%b expected seg=%h", name, vals[i], seg, an, exp_seg(vals[i], idx));
        end
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    q = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};
    repeat (6) q.push_back(8'($urandom_range(0, 255)));
    test_values(q, "random");
  endtask

`ifdef SIGNED_DISP_EN
  task automatic test_signed;
    logic [7:0] q[$];
    q = '{8'hF6, 8'h80, 8'hFF, 8'h7F};
    test_values(q, "signed");
  endtask
`endif

  initial begin
    test_reset;
    test_convert;
    test_back_to_back;
    test_rst_abort;
    test_scan_wrap;
    test_random;
`ifdef SIGNED_DISP_EN
    test_signed;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
